datapath_sequencer: RTL and testbench
=====================================

Name: datapath_sequencer

Overview:
Multi-cycle control unit that sequences the register-file/ALU-mux/ALU datapath. It fetches 32-bit instructions over a valid/ready request and valid response interface, then decodes a minimal RV32I subset (addi, add, sub, beq, bne, ebreak). For each instruction it drives the datapath controls (AD1/AD2/AD3/WE3/ALUsrc/ImmOP/ALUCtrl) for one execute cycle and uses the datapath's EQ to resolve branches. It owns the PC, a retire counter and halt/illegal status.

Parameters:
PC_WIDTH, 32, width of PC and imem_addr
RESET_PC, 0, PC value loaded on reset
ADDRESS_WIDTH, 5, register address width
DATA_WIDTH, 32, instruction/immediate width
ALU_CONTROL_LENGTH, 3, ALUCtrl width
RETIRE_WIDTH, 16, retire counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse to begin execution from PC; honoured only in IDLE
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  fetch request accepted
imem_addr  out  PC_WIDTH  fetch address (= pc)
imem_rsp_valid  in  1  instruction word valid
imem_rsp_data  in  32  instruction word
AD1/AD2/AD3  out  ADDRESS_WIDTH  rs1/rs2/rd to register file
WE3  out  1  register write enable
ALUsrc  out  1  0 = Read2, 1 = ImmOP
ImmOP  out  DATA_WIDTH  sign-extended I-type immediate
ALUCtrl  out  ALU_CONTROL_LENGTH  000 = ADD, 001 = SUB
EQ  in  1  ALU operands equal (combinational from datapath)
pc  out  PC_WIDTH  current PC
busy  out  1  state is REQ/WAIT/EXEC
halted  out  1  state is HALT
illegal  out  1  sticky; HALT entered by an undecodable instruction
retired  out  RETIRE_WIDTH  count of executed instructions

Behaviour:
- Reset (rst high at clk edge): state = IDLE, pc = RESET_PC, retired = 0, illegal = 0, instruction register = 0. Reset overrides every other event.
- Datapath control outputs are combinational from state and the instruction register. Outside EXEC: WE3 = 0, ALUsrc = 0, ImmOP = 0, ALUCtrl = 000, AD* = 0. imem_req_valid = 1 only in REQ.
- FSM:
  - IDLE: if start, go to REQ.
  - REQ: imem_req_valid = 1 and imem_addr = pc, both held stable until imem_req_ready. On ready, go to WAIT.
  - WAIT: on imem_rsp_valid, latch imem_rsp_data into the instruction register and go to EXEC. A response is never accepted in the same cycle as the request handshake.
  - EXEC: lasts exactly one cycle. Decode the latched word:
    - addi (op 0010011, f3 000): AD1 = rs1, AD3 = rd, ALUsrc = 1, ImmOP = sext(inst[31:20]), ALUCtrl = ADD, WE3 = (rd != 0).
    - add/sub (op 0110011, f3 000, f7 0000000/0100000): AD1 = rs1, AD2 = rs2, AD3 = rd, ALUsrc = 0, ALUCtrl = ADD/SUB, WE3 = (rd != 0).
    - beq/bne (op 1100011, f3 000/001): AD1 = rs1, AD2 = rs2, ALUsrc = 0, ALUCtrl = SUB, WE3 = 0. Taken = EQ (beq) or !EQ (bne), sampled in this cycle.
    - After any of the above: pc <= taken ? pc + sext(B-imm) : pc + 4; retired <= retired + 1 (wraps); next state REQ.
    - ebreak (0x00100073): retired += 1, pc unchanged, go to HALT.
    - Any other word: illegal <= 1, WE3 = 0, pc and retired unchanged, go to HALT.
  - HALT: stays until rst; start is ignored.
- PC arithmetic is modulo 2^PC_WIDTH. Misaligned branch targets are not checked.
- start asserted outside IDLE is ignored.
- Reset during WAIT: a response arriving afterwards, while in IDLE, is dropped.
- imem_rsp_valid outside WAIT is ignored.

Decomposition:
- Package seq_pkg holds: state enum (IDLE, REQ, WAIT, EXEC, HALT); opcode/funct3/funct7 constants; ALUCtrl codes ALU_ADD = 3'b000, ALU_SUB = 3'b001; the EBREAK constant.
- One sub-module, seq_decoder: purely combinational; maps instruction to control fields, immediates, is_branch, is_ebreak and is_illegal.

Test Plan:
- Reset: assert rst for 2 cycles -> pc = 0, retired = 0, busy = halted = illegal = 0, WE3 = 0, imem_req_valid = 0.
- Single addi: start, respond 0x00500513 -> in EXEC, AD1 = 0, AD3 = 10, ALUsrc = 1, ImmOP = 5, ALUCtrl = 000, WE3 = 1 for exactly one cycle; then pc = 4, retired = 1, next imem_addr = 4.
- Countdown loop: imem holds [0] 0x00300513 (addi x10,x0,3), [4] 0xFFF50513 (addi x10,x10,-1), [8] 0xFE051EE3 (bne x10,x0,-4), [12] 0x00100073 -> a0 sequence 3,2,1,0; bne taken twice, then not taken; halted = 1, illegal = 0, retired = 8, pc = 12.
- Handshake stall: hold imem_req_ready low 3 cycles, then delay response 4 cycles -> imem_req_valid and imem_addr stable throughout; WE3 stays 0 until EXEC.
- Illegal/x0: respond 0xFFFFFFFF -> halted = 1, illegal = 1, WE3 never 1, pc unchanged. Separately, add x0,x1,x2 (0x00208033) -> WE3 = 0, retired increments.
- Reset mid-op: rst during WAIT, then rsp_valid the next cycle -> state IDLE, no EXEC, retired = 0; a fresh start refetches from RESET_PC.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants for the datapath sequencer: FSM encodings, RV32I decode fields and ALU codes.
package seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_REQ  = 3'd1;
  localparam state_t ST_WAIT = 3'd2;
  localparam state_t ST_EXEC = 3'd3;
  localparam state_t ST_HALT = 3'd4;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

endpackage

// File: rtl/seq_decoder.sv
// Combinational decoder for the supported RV32I subset (addi, add, sub, beq, bne, ebreak).
// Produces raw control fields; the sequencer gates them to the execute cycle.
module seq_decoder
  import seq_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH      = 5,
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned PC_WIDTH           = 32,
  parameter int unsigned ALU_CONTROL_LENGTH = 3
) (
  input  logic [31:0]                   inst,
  output logic [ADDRESS_WIDTH-1:0]      rs1,
  output logic [ADDRESS_WIDTH-1:0]      rs2,
  output logic [ADDRESS_WIDTH-1:0]      rd,
  output logic                          we,
  output logic                          alu_src,
  output logic [DATA_WIDTH-1:0]         imm_i,
  output logic [PC_WIDTH-1:0]           imm_b,
  output logic [ALU_CONTROL_LENGTH-1:0] alu_ctrl,
  output logic                          is_branch,
  output logic                          is_bne,
  output logic                          is_ebreak,
  output logic                          is_illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1_f;
  logic [4:0] rs2_f;
  logic [4:0] rd_f;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign rs1_f  = inst[19:15];
  assign rs2_f  = inst[24:20];
  assign rd_f   = inst[11:7];

  // Branch offset is computed unconditionally; only used when is_branch is set.
  assign imm_b = PC_WIDTH'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));

  always_comb begin
    rs1        = '0;
    rs2        = '0;
    rd         = '0;
    we         = 1'b0;
    alu_src    = 1'b0;
    imm_i      = '0;
    alu_ctrl   = ALU_CONTROL_LENGTH'(ALU_ADD);
    is_branch  = 1'b0;
    is_bne     = 1'b0;
    is_ebreak  = (inst == EBREAK);
    is_illegal = 1'b0;

    case (opcode)
      OP_IMM: begin
        if (funct3 == F3_ADD) begin
          rs1      = ADDRESS_WIDTH'(rs1_f);
          rd       = ADDRESS_WIDTH'(rd_f);
          alu_src  = 1'b1;
          imm_i    = DATA_WIDTH'($signed(inst[31:20]));
          alu_ctrl = ALU_CONTROL_LENGTH'(ALU_ADD);
          we       = (rd_f != 5'd0);
        end else begin
          is_illegal = 1'b1;
        end
      end
      OP_REG: begin
        if (funct3 == F3_ADD && (funct7 == F7_ADD || funct7 == F7_SUB)) begin
          rs1      = ADDRESS_WIDTH'(rs1_f);
          rs2      = ADDRESS_WIDTH'(rs2_f);
          rd       = ADDRESS_WIDTH'(rd_f);
          alu_ctrl = (funct7 == F7_SUB) ? ALU_CONTROL_LENGTH'(ALU_SUB)
                                        : ALU_CONTROL_LENGTH'(ALU_ADD);
          we       = (rd_f != 5'd0);
        end else begin
          is_illegal = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
          rs1       = ADDRESS_WIDTH'(rs1_f);
          rs2       = ADDRESS_WIDTH'(rs2_f);
          alu_ctrl  = ALU_CONTROL_LENGTH'(ALU_SUB);
          is_branch = 1'b1;
          is_bne    = (funct3 == F3_BNE);
        end else begin
          is_illegal = 1'b1;
        end
      end
      default: is_illegal = ~is_ebreak;
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle control unit: fetches over a valid/ready interface, decodes one instruction,
// drives the register-file/ALU controls for a single execute cycle and tracks PC/retire/halt.
module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned          PC_WIDTH           = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC           = '0,
  parameter int unsigned          ADDRESS_WIDTH      = 5,
  parameter int unsigned          DATA_WIDTH         = 32,
  parameter int unsigned          ALU_CONTROL_LENGTH = 3,
  parameter int unsigned          RETIRE_WIDTH       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          imem_req_valid,
  input  logic                          imem_req_ready,
  output logic [PC_WIDTH-1:0]           imem_addr,
  input  logic                          imem_rsp_valid,
  input  logic [31:0]                   imem_rsp_data,
  output logic [ADDRESS_WIDTH-1:0]      AD1,
  output logic [ADDRESS_WIDTH-1:0]      AD2,
  output logic [ADDRESS_WIDTH-1:0]      AD3,
  output logic                          WE3,
  output logic                          ALUsrc,
  output logic [DATA_WIDTH-1:0]         ImmOP,
  output logic [ALU_CONTROL_LENGTH-1:0] ALUCtrl,
  input  logic                          EQ,
  output logic [PC_WIDTH-1:0]           pc,
  output logic                          busy,
  output logic                          halted,
  output logic                          illegal,
  output logic [RETIRE_WIDTH-1:0]       retired
);

  state_t                  state_q, state_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  logic [RETIRE_WIDTH-1:0] retired_q, retired_d;
  logic                    illegal_q, illegal_d;
  logic [31:0]             ir_q, ir_d;

  logic [ADDRESS_WIDTH-1:0]      dec_rs1;
  logic [ADDRESS_WIDTH-1:0]      dec_rs2;
  logic [ADDRESS_WIDTH-1:0]      dec_rd;
  logic                          dec_we;
  logic                          dec_alu_src;
  logic [DATA_WIDTH-1:0]         dec_imm_i;
  logic [PC_WIDTH-1:0]           dec_imm_b;
  logic [ALU_CONTROL_LENGTH-1:0] dec_alu_ctrl;
  logic                          dec_is_branch;
  logic                          dec_is_bne;
  logic                          dec_is_ebreak;
  logic                          dec_is_illegal;

  logic in_exec;
  logic taken;

  seq_decoder #(
    .ADDRESS_WIDTH      (ADDRESS_WIDTH),
    .DATA_WIDTH         (DATA_WIDTH),
    .PC_WIDTH           (PC_WIDTH),
    .ALU_CONTROL_LENGTH (ALU_CONTROL_LENGTH)
  ) u_decoder (
    .inst       (ir_q),
    .rs1        (dec_rs1),
    .rs2        (dec_rs2),
    .rd         (dec_rd),
    .we         (dec_we),
    .alu_src    (dec_alu_src),
    .imm_i      (dec_imm_i),
    .imm_b      (dec_imm_b),
    .alu_ctrl   (dec_alu_ctrl),
    .is_branch  (dec_is_branch),
    .is_bne     (dec_is_bne),
    .is_ebreak  (dec_is_ebreak),
    .is_illegal (dec_is_illegal)
  );

  assign in_exec = (state_q == ST_EXEC);
  // EQ comes straight from the datapath and is only meaningful while the branch operands are driven.
  assign taken   = dec_is_branch & (dec_is_bne ? ~EQ : EQ);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    ir_d      = ir_q;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (imem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          ir_d    = imem_rsp_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (dec_is_illegal) begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end else if (dec_is_ebreak) begin
          retired_d = retired_q + RETIRE_WIDTH'(1);
          state_d   = ST_HALT;
        end else begin
          pc_d      = taken ? pc_q + dec_imm_b : pc_q + PC_WIDTH'(4);
          retired_d = retired_q + RETIRE_WIDTH'(1);
          state_d   = ST_REQ;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      illegal_q <= 1'b0;
      ir_q      <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      ir_q      <= ir_d;
    end
  end

  always_comb begin
    AD1     = '0;
    AD2     = '0;
    AD3     = '0;
    WE3     = 1'b0;
    ALUsrc  = 1'b0;
    ImmOP   = '0;
    ALUCtrl = ALU_CONTROL_LENGTH'(ALU_ADD);
    if (in_exec) begin
      AD1     = dec_rs1;
      AD2     = dec_rs2;
      AD3     = dec_rd;
      WE3     = dec_we;
      ALUsrc  = dec_alu_src;
      ImmOP   = dec_imm_i;
      ALUCtrl = dec_alu_ctrl;
    end
  end

  assign imem_req_valid = (state_q == ST_REQ);
  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign busy           = (state_q == ST_REQ) || (state_q == ST_WAIT) || in_exec;
  assign halted         = (state_q == ST_HALT);
  assign illegal        = illegal_q;
  assign retired        = retired_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: an instruction-level model of the program plus a small
// register-file/ALU stand-in that closes the EQ loop, checked every cycle.
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_addr, imem_rsp_data, ImmOP, pc;
  logic [4:0]  AD1, AD2, AD3;
  logic        WE3, ALUsrc, EQ, busy, halted, illegal;
  logic [2:0]  ALUCtrl;
  logic [15:0] retired;

  always #5 clk = ~clk;

  datapath_sequencer #(
    .PC_WIDTH           (32),
    .RESET_PC           (32'h0),
    .ADDRESS_WIDTH      (5),
    .DATA_WIDTH         (32),
    .ALU_CONTROL_LENGTH (3),
    .RETIRE_WIDTH       (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .AD1            (AD1),
    .AD2            (AD2),
    .AD3            (AD3),
    .WE3            (WE3),
    .ALUsrc         (ALUsrc),
    .ImmOP          (ImmOP),
    .ALUCtrl        (ALUCtrl),
    .EQ             (EQ),
    .pc             (pc),
    .busy           (busy),
    .halted         (halted),
    .illegal        (illegal),
    .retired        (retired)
  );

  // Register file + ALU environment driven by the DUT controls.
  logic [31:0] dp_rf [32];
  logic        dp_clear;
  logic [31:0] a0_log [$];
  logic [31:0] dp_a, dp_b, dp_res;

  always_comb begin
    dp_a   = dp_rf[AD1];
    dp_b   = ALUsrc ? ImmOP : dp_rf[AD2];
    dp_res = (ALUCtrl == 3'b001) ? dp_a - dp_b : dp_a + dp_b;
  end
  assign EQ = (dp_a == dp_b);

  always @(posedge clk) begin
    if (dp_clear) begin
      for (int i = 0; i < 32; i++) dp_rf[i] <= 32'h0;
      a0_log.delete();
    end else if (WE3 && AD3 != 5'd0) begin
      dp_rf[AD3] <= dp_res;
      if (AD3 == 5'd10) a0_log.push_back(dp_res);
    end
  end

  // Architectural model. ph: 0 idle, 1 fetch request, 2 awaiting response, 3 execute, 4 halted.
  int          ph;
  logic [31:0] m_pc;
  logic [15:0] m_ret;
  logic        m_ill;
  logic [31:0] m_rf [32];
  logic [31:0] imem [64];
  logic [31:0] cur;

  logic        e_we, e_src;
  logic [4:0]  e_ad1, e_ad2, e_ad3;
  logic [31:0] e_imm;
  logic [2:0]  e_alu;
  bit          ck_ad1, ck_ad2, ck_ad3, ck_imm, ck_src, ck_alu;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  localparam logic [31:0] EBRK = 32'h0010_0073;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // 0 illegal, 1 addi, 2 add, 3 sub, 4 beq, 5 bne, 6 ebreak
  function automatic int kind(input logic [31:0] w);
    logic [6:0] op = w[6:0];
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    if (w == EBRK) return 6;
    if (op == 7'h13 && f3 == 3'd0) return 1;
    if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h00) return 2;
    if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20) return 3;
    if (op == 7'h63 && f3 == 3'd0) return 4;
    if (op == 7'h63 && f3 == 3'd1) return 5;
    return 0;
  endfunction

  function automatic logic [31:0] sext_i(input logic [31:0] w);
    return {{20{w[31]}}, w[31:20]};
  endfunction

  function automatic logic [31:0] sext_b(input logic [31:0] w);
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  task automatic set_exp(input logic [31:0] w);
    int k = kind(w);
    {e_we, e_src, e_ad1, e_ad2, e_ad3, e_imm, e_alu} = '0;
    {ck_ad1, ck_ad2, ck_ad3, ck_imm, ck_src, ck_alu} = '0;
    if (k >= 1 && k <= 5) begin
      e_ad1 = w[19:15]; ck_ad1 = 1; ck_src = 1; ck_alu = 1;
    end
    if (k == 1) begin
      e_ad3 = w[11:7]; ck_ad3 = 1; e_src = 1; e_imm = sext_i(w); ck_imm = 1;
      e_we = (w[11:7] != 0);
    end
    if (k == 2 || k == 3) begin
      e_ad2 = w[24:20]; ck_ad2 = 1; e_ad3 = w[11:7]; ck_ad3 = 1;
      e_alu = (k == 3) ? 3'b001 : 3'b000; e_we = (w[11:7] != 0);
    end
    if (k == 4 || k == 5) begin
      e_ad2 = w[24:20]; ck_ad2 = 1; e_alu = 3'b001;
    end
  endtask

  task automatic exec_model(input logic [31:0] w);
    int          k  = kind(w);
    logic [4:0]  rd = w[11:7];
    logic [31:0] a  = m_rf[w[19:15]];
    logic [31:0] b  = m_rf[w[24:20]];
    bit          tk = 0;
    case (k)
      0: begin m_ill = 1; ph = 4; end
      6: begin m_ret++; ph = 4; end
      default: begin
        if (k == 1 && rd != 0) m_rf[rd] = a + sext_i(w);
        if (k == 2 && rd != 0) m_rf[rd] = a + b;
        if (k == 3 && rd != 0) m_rf[rd] = a - b;
        if (k == 4) tk = (a == b);
        if (k == 5) tk = (a != b);
        m_pc = tk ? m_pc + sext_b(w) : m_pc + 32'd4;
        m_ret++;
        ph = 1;
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(ph >= 1 && ph <= 3));
      check("halted", 32'(halted), 32'(ph == 4));
      check("illegal", 32'(illegal), 32'(m_ill));
      check("pc", pc, m_pc);
      check("imem_addr", imem_addr, m_pc);
      check("retired", 32'(retired), 32'(m_ret));
      check("imem_req_valid", 32'(imem_req_valid), 32'(ph == 1));
      if (ph == 3) begin
        check("exec_WE3", 32'(WE3), 32'(e_we));
        if (ck_ad1) check("exec_AD1", 32'(AD1), 32'(e_ad1));
        if (ck_ad2) check("exec_AD2", 32'(AD2), 32'(e_ad2));
        if (ck_ad3) check("exec_AD3", 32'(AD3), 32'(e_ad3));
        if (ck_src) check("exec_ALUsrc", 32'(ALUsrc), 32'(e_src));
        if (ck_imm) check("exec_ImmOP", ImmOP, e_imm);
        if (ck_alu) check("exec_ALUCtrl", 32'(ALUCtrl), 32'(e_alu));
      end else begin
        check("idle_WE3", 32'(WE3), 32'h0);
        check("idle_ALUsrc", 32'(ALUsrc), 32'h0);
        check("idle_ImmOP", ImmOP, 32'h0);
        check("idle_ALUCtrl", 32'(ALUCtrl), 32'h0);
        check("idle_AD", 32'({AD1, AD2, AD3}), 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1; start = 0; imem_req_ready = 0; imem_rsp_valid = 0; dp_clear = 1;
    tick();
    ph = 0; m_pc = 0; m_ret = 0; m_ill = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    chk_en = 1;
    repeat (n - 1) tick();
    rst = 0; dp_clear = 0;
  endtask

  // From a pending request up to the start of the execute cycle; junk on rsp/start is ignored.
  task automatic fetch_to_exec(input int rdy_dly, input int rsp_dly);
    for (int i = 0; i < rdy_dly; i++) begin
      imem_req_ready = 0;
      imem_rsp_valid = 1'($urandom_range(0, 1));
      imem_rsp_data  = $urandom;
      start          = 1'($urandom_range(0, 1));
      tick();
    end
    imem_req_ready = 1; imem_rsp_valid = 0;
    tick();
    imem_req_ready = 0; ph = 2;
    for (int i = 0; i < rsp_dly; i++) begin
      imem_rsp_data = $urandom;
      start         = 1'($urandom_range(0, 1));
      tick();
    end
    start = 0;
    cur = imem[m_pc[7:2]];
    imem_rsp_valid = 1; imem_rsp_data = cur;
    tick();
    imem_rsp_valid = 0; imem_rsp_data = $urandom; ph = 3;
    set_exp(cur);
  endtask

  task automatic finish_exec();
    start = 1'($urandom_range(0, 1));
    tick();
    start = 0;
    exec_model(cur);
  endtask

  task automatic run_program(input int max_instr);
    start = 1;
    tick();
    start = 0; ph = 1;
    for (int n = 0; n < max_instr && ph == 1; n++) begin
      fetch_to_exec($urandom_range(0, 3), $urandom_range(0, 3));
      finish_exec();
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = EBRK;
  endtask

  function automatic logic [31:0] gen_instr();
    int          r   = $urandom_range(0, 99);
    logic [4:0]  rd  = 5'($urandom_range(0, 7));
    logic [4:0]  rs1 = 5'($urandom_range(0, 7));
    logic [4:0]  rs2 = 5'($urandom_range(0, 7));
    logic [11:0] i12 = 12'($urandom_range(0, 16)) - 12'd8;
    logic [12:0] b13 = 13'($urandom_range(0, 16) * 4) - 13'd32;
    logic [6:0]  f7  = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    logic [2:0]  f3b = 3'($urandom_range(0, 1));
    if (r < 30) return {i12, rs1, 3'b000, rd, 7'b0010011};
    if (r < 55) return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    if (r < 85) return {b13[12], b13[10:5], rs2, rs1, f3b, b13[4:1], b13[11], 7'b1100011};
    if (r < 90) return EBRK;
    if (r < 95) return {7'b0000001, rs2, rs1, 3'b000, rd, 7'b0110011};
    return $urandom;
  endfunction

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, want self-termination");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; start = 0; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    dp_clear = 1; ph = 0; m_pc = 0; m_ret = 0; m_ill = 0; cur = 0;
    clear_imem();

    // Reset state.
    do_reset(2);
    check("rst_pc", pc, 32'h0);
    check("rst_retired", 32'(retired), 32'h0);
    check("rst_status", 32'({busy, halted, illegal, WE3, imem_req_valid}), 32'h0);

    // Single addi x10, x0, 5 with literal expectations.
    imem[0] = 32'h0050_0513;
    start = 1; tick(); start = 0; ph = 1;
    fetch_to_exec(0, 0);
    #3;
    check("addi_AD1", 32'(AD1), 32'd0);
    check("addi_AD3", 32'(AD3), 32'd10);
    check("addi_ALUsrc", 32'(ALUsrc), 32'd1);
    check("addi_ImmOP", ImmOP, 32'd5);
    check("addi_ALUCtrl", 32'(ALUCtrl), 32'd0);
    check("addi_WE3", 32'(WE3), 32'd1);
    finish_exec();
    check("addi_pc", pc, 32'd4);
    check("addi_retired", 32'(retired), 32'd1);
    check("addi_next_addr", imem_addr, 32'd4);
    check("addi_req_valid", 32'(imem_req_valid), 32'd1);
    fetch_to_exec(0, 0);
    finish_exec();
    check("addi_x10", dp_rf[10], 32'd5);

    // Countdown loop with a data-dependent bne.
    clear_imem();
    imem[0] = 32'h0030_0513;
    imem[1] = 32'hFFF5_0513;
    imem[2] = 32'hFE05_1EE3;
    imem[3] = EBRK;
    do_reset(2);
    run_program(20);
    check("loop_halted", 32'(halted), 32'd1);
    check("loop_illegal", 32'(illegal), 32'd0);
    check("loop_retired", 32'(retired), 32'd8);
    check("loop_pc", pc, 32'd12);
    check("loop_a0_writes", 32'(a0_log.size()), 32'd4);
    for (int i = 0; i < a0_log.size() && i < 4; i++) check("loop_a0_value", a0_log[i], 32'(3 - i));
    start = 1; tick(); tick(); start = 0; tick();
    check("halt_ignores_start", 32'(halted), 32'd1);

    // Handshake stalls: ready held low 3 cycles, response delayed 4 cycles.
    clear_imem();
    imem[0] = 32'h0050_0513;
    do_reset(2);
    start = 1; tick(); start = 0; ph = 1;
    fetch_to_exec(3, 4);
    finish_exec();
    fetch_to_exec(2, 1);
    finish_exec();

    // Undecodable word.
    clear_imem();
    imem[0] = 32'hFFFF_FFFF;
    do_reset(2);
    run_program(3);
    check("ill_halted", 32'(halted), 32'd1);
    check("ill_illegal", 32'(illegal), 32'd1);
    check("ill_pc", pc, 32'd0);
    check("ill_retired", 32'(retired), 32'd0);
    do_reset(1);
    check("ill_cleared", 32'(illegal), 32'd0);

    // add x0, x1, x2 must not write but still retires.
    clear_imem();
    imem[0] = 32'h0020_8033;
    do_reset(2);
    run_program(3);
    check("x0_retired", 32'(retired), 32'd2);
    check("x0_pc", pc, 32'd4);

    // Reset while awaiting a response; the late response must be dropped.
    clear_imem();
    imem[0] = 32'h0050_0513;
    do_reset(2);
    start = 1; tick(); start = 0; ph = 1;
    imem_req_ready = 1; tick(); imem_req_ready = 0; ph = 2;
    tick();
    rst = 1; tick(); rst = 0;
    ph = 0; m_pc = 0; m_ret = 0; m_ill = 0;
    imem_rsp_valid = 1; imem_rsp_data = imem[0]; tick(); imem_rsp_valid = 0;
    repeat (2) tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_retired", 32'(retired), 32'd0);
    check("midrst_x10", dp_rf[10], 32'd0);
    run_program(5);
    check("midrst_refetch_retired", 32'(retired), 32'd2);
    check("midrst_refetch_x10", dp_rf[10], 32'd5);

    // Random programs against the model.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 64; i++) imem[i] = gen_instr();
      do_reset($urandom_range(1, 3));
      run_program(40);
      for (int r = 1; r < 8; r++) check("rand_regfile", dp_rf[r], m_rf[r]);
    end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
